// File: rtl/grant_seq_pkg.sv
// Shared constants and FSM state type for the grant index sequencer.
package grant_seq_pkg;

    localparam int NUM_CH = 8;
    localparam int IDX_W  = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/grant_index_sequencer_rr_pick.sv
// rr_pick: combinational rotated-priority search. Returns the first set
// request bit at or above ptr, wrapping from channel 7 back to channel 0.
module rr_pick
    import grant_seq_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic              any,
    output logic [IDX_W-1:0]  idx
);

    logic [2*NUM_CH-1:0] w_dbl;
    logic [NUM_CH-1:0]   w_rot;
    logic [IDX_W-1:0]    w_off;

    // Rotate the request vector so that channel ptr lands at bit 0.
    assign w_dbl = {req, req} >> ptr;
    assign w_rot = w_dbl[NUM_CH-1:0];

    // Find the lowest set bit of the rotated vector; the downward loop leaves
    // the smallest offset as the final assignment.
    always_comb begin
        any   = |w_rot;
        w_off = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IDX_W'(k);
            end
        end
    end

    // Offset back to an absolute channel index; 3-bit addition wraps 7->0.
    assign idx = ptr + w_off;

endmodule

// File: rtl/grant_index_sequencer.sv
// grant_index_sequencer: two-state round-robin grant FSM over 8 level
// requests. A grant is held until ack; the next search starts just above the
// released channel. Optional feature macro GRANT_TIMEOUT_EN revokes a grant
// after TIMEOUT_CYCLES cycles without ack and raises a sticky timeout flag.
module grant_index_sequencer
    import grant_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              ack,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic              gnt_valid,
    output logic              timeout
);

    state_t           r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_idx;
    logic             w_any;
    logic [IDX_W-1:0] w_pick;

    rr_pick u_rr_pick (
        .req (req),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_pick)
    );

`ifdef GRANT_TIMEOUT_EN
    logic       r_to;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;

    assign w_cnt_nxt = r_cnt + 8'd1;

    // Grant FSM with timeout: ack has priority over counter expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_to    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_idx   <= w_pick;
                        r_cnt   <= '0;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (ack) begin
                        r_ptr   <= r_idx + 3'd1;
                        r_state <= IDLE;
                    end else if (w_cnt_nxt == 8'(TIMEOUT_CYCLES)) begin
                        r_ptr   <= r_idx + 3'd1;
                        r_to    <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt   <= w_cnt_nxt;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign timeout = r_to;
`else
    logic w_unused_cfg;

    // The timeout length only matters when the timeout feature is built in.
    assign w_unused_cfg = ^8'(TIMEOUT_CYCLES);

    // Grant FSM: a grant is held until ack, however long that takes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_idx   <= w_pick;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (ack) begin
                        r_ptr   <= r_idx + 3'd1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign timeout = 1'b0;
`endif

    assign gnt_idx   = r_idx;
    assign gnt_valid = (r_state == GRANT);

endmodule

// File: tb/tb_grant_index_sequencer.sv
// Directed bench for grant_index_sequencer with a cycle-level reference model.
// Covers the GRANT_TIMEOUT_EN build when that macro is defined.
module tb_grant_index_sequencer;

    localparam int TO = 16;
`ifdef GRANT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ack = 1'b0;
    logic [7:0] req = 8'h00;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // reference model state
    bit   m_valid = 1'b0;
    int   m_idx   = 0;
    int   m_ptr   = 0;
    bit   m_to    = 1'b0;
    int   m_hold  = 0;

    grant_index_sequencer #(.TIMEOUT_CYCLES(TO)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .ack       (ack),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Reference model: advances on each rising edge from the sampled inputs.
    always @(posedge clk) begin
        bit found;
        if (rst) begin
            m_valid = 1'b0; m_idx = 0; m_ptr = 0; m_to = 1'b0; m_hold = 0;
        end else if (!m_valid) begin
            found = 1'b0;
            for (int k = 0; k < 8; k++) begin
                int c;
                c = (m_ptr + k) % 8;
                if (!found && req[c]) begin
                    found = 1'b1; m_idx = c;
                end
            end
            if (found) begin
                m_valid = 1'b1; m_hold = 0;
            end
        end else begin
            m_hold = m_hold + 1;
            if (ack) begin
                m_ptr = (m_idx + 1) % 8; m_valid = 1'b0;
            end else if (TO_EN && m_hold >= TO) begin
                m_ptr = (m_idx + 1) % 8; m_valid = 1'b0; m_to = 1'b1;
            end
        end
    end

    // Compare DUT against model on every falling edge once out of initial reset.
    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            if (gnt_valid !== m_valid || timeout !== m_to || int'(gnt_idx) != m_idx) begin
                n_bad++;
                $display("FAIL model t=%0t: valid/idx/timeout got %0b/%0d/%0b want %0b/%0d/%0b",
                         $time, gnt_valid, gnt_idx, timeout, m_valid, m_idx, m_to);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Steps until a grant shows (bounded); checks index and 1-cycle latency.
    task automatic wait_grant(input string nm, input int exp);
        int n;
        n = 0;
        step();
        while (!gnt_valid && n < 16) begin
            step();
            n++;
        end
        if (!gnt_valid) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: no grant within 16 cycles got valid=0 want 1", nm);
        end else begin
            chk(nm, gnt_idx, exp);
            chk({nm, "_lat"}, n, 0);
        end
    endtask

    task automatic release_gnt(input string nm);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk(nm, gnt_valid, 0);
    endtask

    initial begin
        int rr_exp[4];
        rr_exp = '{2, 7, 2, 7};

        rst = 1'b1;
        step();
        step();
        chk_en = 1'b1;
        rst = 1'b0;

        // idle after reset with no requests
        req = 8'h00;
        repeat (5) begin
            step();
            chk("idle_valid", gnt_valid, 0);
            chk("idle_idx", gnt_idx, 0);
            chk("idle_to", timeout, 0);
        end

        // round robin over channels 2 and 7, pointer wraps 7->0
        req = 8'b1000_0100;
        for (int i = 0; i < 4; i++) begin
            wait_grant("rr_grant", rr_exp[i]);
            release_gnt("rr_release");
        end
        req = 8'h00;

        // grant index stays stable while requests change
        req = 8'h20;
        wait_grant("stab_first", 5);
        req = 8'h02;
        repeat (3) begin
            step();
            chk("stab_idx", gnt_idx, 5);
            chk("stab_valid", gnt_valid, 1);
        end
        release_gnt("stab_release");
        wait_grant("stab_next", 1);
        release_gnt("stab_release2");
        req = 8'h00;

        // ack while idle is ignored: index held, pointer unchanged (2)
        ack = 1'b1;
        step();
        step();
        ack = 1'b0;
        chk("idle_ack_valid", gnt_valid, 0);
        chk("idle_ack_idx", gnt_idx, 1);
        req = 8'hFF;
        wait_grant("ptr_kept", 2);
        release_gnt("ptr_kept_rel");

        // reset mid-grant with coincident ack
        req = 8'h08;
        wait_grant("pre_rst", 3);
        rst = 1'b1;
        ack = 1'b1;
        step();
        chk("rst_valid", gnt_valid, 0);
        chk("rst_idx", gnt_idx, 0);
        chk("rst_to", timeout, 0);
        rst = 1'b0;
        ack = 1'b0;
        req = 8'hFF;
        wait_grant("post_rst", 0);
        release_gnt("post_rst_rel");
        req = 8'h00;

`ifdef GRANT_TIMEOUT_EN
        // timeout after 16 grant cycles without ack
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 8'h10;
        wait_grant("to_grant", 4);
        req = 8'h00;
        repeat (15) begin
            step();
            chk("to_hold", gnt_valid, 1);
            chk("to_flag0", timeout, 0);
        end
        step();
        chk("to_release", gnt_valid, 0);
        chk("to_flag", timeout, 1);
        req = 8'h11;
        wait_grant("to_wrap", 0);
        chk("to_sticky", timeout, 1);
        release_gnt("to_rel2");
        chk("to_sticky2", timeout, 1);
        req = 8'h00;

        // ack in the 16th grant cycle wins over expiry
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 8'h10;
        wait_grant("ack16_grant", 4);
        req = 8'h00;
        repeat (15) step();
        chk("ack16_valid", gnt_valid, 1);
        release_gnt("ack16_release");
        chk("ack16_to", timeout, 0);
`else
        // without the timeout feature a grant is held indefinitely
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 8'h10;
        wait_grant("hold_grant", 4);
        req = 8'h00;
        repeat (100) step();
        chk("hold_valid", gnt_valid, 1);
        chk("hold_idx", gnt_idx, 4);
        chk("hold_to", timeout, 0);
        release_gnt("hold_release");
        chk("hold_to2", timeout, 0);
`endif

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/grant_index_sequencer.md
GRANT_INDEX_SEQUENCER -- requirements
Module: grant_index_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, the number of grant cycles without ack before the grant is revoked (range 2..255; used only with GRANT_TIMEOUT_EN).
REQ-002 Port: clk, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-003 Port: rst, input, 1 bit, synchronous active-high reset.
REQ-004 Port: req, input, 8 bits, level request per channel; bit i is channel i.
REQ-005 Port: ack, input, 1 bit, consumer done with the current grant; sampled only while gnt_valid=1.
REQ-006 Port: gnt_idx, output, 3 bits, registered binary index of the granted channel; drives the downstream 3-to-8 decoder select.
REQ-007 Port: gnt_valid, output, 1 bit, registered; gnt_idx is meaningful only while this is 1.
REQ-008 Port: timeout, output, 1 bit, sticky revoke flag; constant 0 without GRANT_TIMEOUT_EN.

Function
REQ-009 The FSM SHALL have exactly two states: IDLE (gnt_valid=0) and GRANT (gnt_valid=1).
REQ-010 In IDLE with req!=0, pick the first set req bit scanning upward from ptr with wrap 7->0, load gnt_idx, and enter GRANT at the next edge (latency 1 cycle from req to gnt_valid).
REQ-011 In IDLE with req=0, remain in IDLE; gnt_idx holds its last value.
REQ-012 In GRANT, gnt_idx SHALL stay stable regardless of req changes, including deassertion of the granted bit, until release.
REQ-013 In GRANT with ack=1, set ptr to (gnt_idx+1) mod 8 (7 wraps to 0) and return to IDLE; at least one IDLE cycle separates consecutive grants.
REQ-014 ptr is a 3-bit internal register; it changes only on release (ack or timeout).
REQ-015 An ack received while in IDLE SHALL be ignored with no state change.
REQ-016 Selection SHALL be fair: a channel holding req continuously is granted within 8 grants.

Reset
REQ-017 rst=1 at a rising edge SHALL force: state IDLE, ptr=0, gnt_idx=0, gnt_valid=0, timeout=0, timeout counter=0.
REQ-018 Reset SHALL take priority over every other event, including mid-grant and coincident ack; gnt_valid is 0 in the cycle after reset is sampled.

Configuration
REQ-019 Macro GRANT_TIMEOUT_EN: when defined, an 8-bit counter increments each GRANT cycle without ack; when it reaches TIMEOUT_CYCLES, release as for ack (ptr advance, go to IDLE) and set timeout=1.
REQ-020 The timeout flag is sticky: it is cleared only by rst.
REQ-021 If ack and timeout expiry coincide, ack wins and timeout is not set.
REQ-022 The counter clears on every entry to GRANT.
REQ-023 Without the macro, there is no counter logic, a grant is held until ack indefinitely, and timeout is tied to 0.

Structure
REQ-024 Shared package grant_seq_pkg SHALL hold: the constants NUM_CH=8 and IDX_W=3, and the state enum type {IDLE, GRANT}.
REQ-025 Sub-module rr_pick SHALL be combinational (req[7:0], ptr[2:0] -> any, idx[2:0]) and implement the rotated priority search; all registers live in grant_index_sequencer.

Verification
REQ-026 Reset, then req=8'h00 for 5 cycles -> gnt_valid=0, gnt_idx=0, timeout=0 throughout.
REQ-027 Round robin: ptr=0, req=8'b1000_0100 held, ack one cycle after each grant -> grants in order 2, 7, 2, 7; ptr wraps 7->0.
REQ-028 Stability: grant idx 5, then drop req[5] and raise req[1] while ack=0 -> gnt_idx stays 5 until ack; next grant is 1.
REQ-029 Reset mid-grant: in GRANT idx 3, assert rst with ack=1 -> next cycle gnt_valid=0, gnt_idx=0; next grant from req=8'hFF is 0.
REQ-030 With GRANT_TIMEOUT_EN and TIMEOUT_CYCLES=16: grant idx 4, never ack -> release after 16 GRANT cycles, timeout=1 and stays 1; next grant from req=8'h11 is 0 (ptr=5, wrap).
REQ-031 With GRANT_TIMEOUT_EN: ack in the 16th cycle -> normal release, timeout stays 0; without the macro, the same stimulus holds the grant for 100 cycles with timeout=0.
